// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional quotient-overflow flag output is compiled in with `define SEQ_DIVIDER_OVF_CHECK_EN.
module seq_divider #(
    parameter int DW = 10,
    parameter int VW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
    output logic          ovf,
`endif
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_dz;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
    logic          r_ovf;
`endif

    // The shifted partial remainder carries one extra bit so it can exceed any divisor.
    logic [VW:0]   w_prem;
    logic          w_ge;
    logic [VW-1:0] w_diff;
    logic [VW-1:0] w_rem_next;
    logic [DW-1:0] w_quot_next;

    assign w_prem      = {r_rem, r_dvd[DW-1]};
    assign w_ge        = (w_prem >= {1'b0, r_dvs});
    assign w_diff      = VW'(w_prem - {1'b0, r_dvs});
    assign w_rem_next  = w_ge ? w_diff : w_prem[VW-1:0];
    assign w_quot_next = {r_quot[DW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                // DONE accepts a new request exactly like IDLE so ops can run back to back.
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_rem  <= '0;
                        r_cnt  <= CW'(DW - 1);
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
                        r_ovf  <= 1'b0;
`endif
                        if (divisor == '0) begin
                            r_quot  <= '1;
                            r_dz    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
                            r_ovf   <= 1'b1;
`endif
                        end else begin
                            r_quot  <= '0;
                            r_dz    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_dvd  <= r_dvd << 1;
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
                        r_ovf   <= |w_quot_next[DW-1:VW];
`endif
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results, one task per scenario.
// Checks the ovf output too when SEQ_DIVIDER_OVF_CHECK_EN is defined.
module tb_seq_divider;

    localparam int DW = 10;
    localparam int VW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
    logic          ovf;
`endif

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          ov;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
        .ovf       (ovf),
`endif
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer division, with the divide-by-zero convention.
    task automatic pushExpected(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = '0;
            e.dz = 1'b1;
            e.ov = 1'b1;
        end else begin
            e.q  = DW'(a / b);
            e.r  = VW'(a % b);
            e.dz = 1'b0;
            e.ov = ((a / b) > 31);
        end
        sb.push_back(e);
    endtask

    task automatic issueOp(input int a, input int b);
        dividend = DW'(a);
        divisor  = VW'(b);
        start    = 1'b1;
        pushExpected(a, b);
    endtask

    // Waits for done (bounded), scrambling operands after the accept and optionally re-pulsing start.
    task automatic awaitResult(input string name, input int expLat, input int injectAt,
                               output int busyCycles);
        int   cnt;
        bit   seen;
        exp_t e;
        cnt        = 0;
        seen       = 1'b0;
        busyCycles = 0;
        while (cnt < 40 && !seen) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start    = 1'b0;
                dividend = ~dividend;
                divisor  = ~divisor;
            end
            if (injectAt != 0 && cnt == injectAt) begin
                start    = 1'b1;
                dividend = DW'($urandom_range(0, 1023));
                divisor  = VW'($urandom_range(1, 31));
            end
            if (injectAt != 0 && cnt == injectAt + 1) start = 1'b0;
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done not seen after %0d cycles, required at %0d", name, cnt, expLat);
        end else if (cnt !== expLat) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", name, cnt, expLat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected one entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (quotient !== e.q) begin
                errors++;
                $display("[TB] FAIL %s_quotient: got %0d expected %0d", name, quotient, e.q);
            end
            checks++;
            if (remainder !== e.r) begin
                errors++;
                $display("[TB] FAIL %s_remainder: got %0d expected %0d", name, remainder, e.r);
            end
            checks++;
            if (div_zero !== e.dz) begin
                errors++;
                $display("[TB] FAIL %s_div_zero: got %0b expected %0b", name, div_zero, e.dz);
            end
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
            checks++;
            if (ovf !== e.ov) begin
                errors++;
                $display("[TB] FAIL %s_ovf: got %0b expected %0b", name, ovf, e.ov);
            end
`endif
        end
    endtask

    task automatic checkAllZero(input string name);
        checks++;
        if ({busy, done, quotient, remainder, div_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, expected all 0",
                     name, busy, done, quotient, remainder, div_zero);
        end
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_ovf: got %0b expected 0", name, ovf);
        end
`endif
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 10'd5;
        divisor  = 5'd1;
        repeat (3) @(negedge clk);
        checkAllZero("reset_state");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checkAllZero("idle_after_reset");
    endtask

    task automatic test_basic();
        int bc;
        issueOp(156, 12);
        awaitResult("basic_156_12", 11, 0, bc);
        checks++;
        if (bc !== 10) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d expected 10", bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 10'd13) begin
            errors++;
            $display("[TB] FAIL basic_hold: got done=%0b q=%0d expected done=0 q=13", done, quotient);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        issueOp(961, 31);
        awaitResult("b2b_961_31", 11, 0, bc);
        issueOp(1000, 7);
        awaitResult("b2b_1000_7", 11, 0, bc);
    endtask

    task automatic test_max();
        int bc;
        issueOp(1023, 1);
        awaitResult("max_1023_1", 11, 0, bc);
        issueOp(961, 31);
        awaitResult("fit_961_31", 11, 0, bc);
    endtask

    task automatic test_div_zero();
        int bc;
        issueOp(100, 0);
        awaitResult("divzero_100_0", 1, 0, bc);
        issueOp(50, 3);
        awaitResult("after_divzero_50_3", 11, 0, bc);
    endtask

    task automatic test_ignore_start();
        int bc;
        issueOp(700, 9);
        awaitResult("ignore_700_9", 11, 3, bc);
    endtask

    task automatic test_reset_mid();
        int bc;
        dividend = 10'd777;
        divisor  = 5'd13;
        start    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_busy: got %0b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("reset_midop");
        rst = 1'b0;
        @(negedge clk);
        issueOp(500, 25);
        awaitResult("post_reset_500_25", 11, 0, bc);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_max();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse operation to the team's 5x5 array multiplier: it splits a 10-bit product back into a quotient and a remainder.
- It produces one quotient bit per clock and uses a start/busy/done handshake.
- It sits in the datapath beside the multiplier, where normalisation and scaling steps need division.

Parameters:
- DW, 10, dividend width; the quotient is also DW bits.
- VW, 5, divisor width; the remainder is also VW bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only when not busy
- dividend  input  DW  numerator; captured on the accepting edge
- divisor  input  VW  denominator; captured on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  DW  result; held until the next accepted start
- remainder  output  VW  result; held until the next accepted start
- div_zero  output  1  set when the captured divisor was 0; held with the results

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset forces state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0 (and ovf=0 when the optional feature is compiled in). This holds even in the middle of an operation. Reset has priority over start.
- State IDLE: start=1 is accepted at the clock edge.
  - Capture dividend and divisor.
  - Clear the partial remainder (VW+1 bits) and the quotient register.
  - Load the bit counter with DW-1.
  - If the divisor is nonzero, go to CALC. If it is 0, go to DONE.
- State CALC (busy=1), each cycle:
  - Shift the partial remainder left by 1 and bring in the next dividend bit, MSB first.
  - If partial remainder >= divisor: subtract the divisor and write quotient bit 1. Otherwise keep it and write quotient bit 0.
  - Decrement the counter. Leave CALC after DW iterations; the iteration with counter=0 is the last.
- State DONE: done=1 for exactly one cycle, busy=0. Results are valid from this cycle and stay stable afterwards. The next state is IDLE.
- Back-to-back operation: start=1 during the DONE cycle is accepted exactly as in IDLE, so the next operation begins at the next edge.
- Latency (nonzero divisor): done is high in the cycle after the (DW+1)-th rising edge, counting the accepting edge as edge 1. For DW=10, done is high 11 cycles after the accept.
- Latency (divisor 0): done is high in the cycle after the accepting edge (1-cycle latency).
- Divide by zero: quotient = all ones (10'h3FF), remainder = 0, div_zero=1.
- Otherwise div_zero is cleared on accept.
- start while busy=1 is ignored. It does not queue, and it does not disturb the captured operands.
- Changes to the dividend and divisor inputs after the accept have no effect.
- Arithmetic invariants:
  - dividend = quotient*divisor + remainder.
  - remainder < divisor.
  - The partial remainder needs VW+1 bits so that the shifted value cannot overflow.

Optional Feature:
- Macro: SEQ_DIVIDER_OVF_CHECK_EN.
- When defined:
  - Adds output ovf (1 bit), with reset value 0. It is updated in the DONE cycle and held with the results.
  - ovf=1 when quotient > 2^VW - 1, i.e. the quotient cannot be a 5-bit multiplier operand.
  - A divide by zero also sets ovf=1.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- reset, then dividend=156, divisor=12, start 1 cycle -> done exactly 11 cycles later; quotient=13, remainder=0, div_zero=0; busy high for 10 cycles.
- dividend=961, divisor=31 -> quotient=31, remainder=0. Then dividend=1000, divisor=7 -> quotient=142, remainder=6. Issue the second start during the first op's DONE cycle; it is accepted with no idle gap.
- dividend=1023, divisor=1 -> quotient=1023, remainder=0. With SEQ_DIVIDER_OVF_CHECK_EN defined -> ovf=1. With dividend=961, divisor=31 -> ovf=0.
- dividend=100, divisor=0 -> done 1 cycle after the accept; quotient=10'h3FF, remainder=0, div_zero=1. The next valid op clears div_zero.
- start pulsed again 3 cycles into an op, with different operands -> ignored; the original result is produced at the original done time.
- rst asserted at the 5th CALC cycle -> next cycle busy=0, done=0, all outputs 0. A fresh start afterwards computes 500/25=20 r 0 correctly.
